// File: rtl/smvm_row_sequencer_if.sv
// -----------------------------------------------------------------------------
// smvm_row_sequencer_if
// Bundles the signals of the SMVM row sequencer. This covers the row-descriptor
// handshake, the element fetch handshake, and the accumulator and status
// strobes.
//
// Modports:
//   master - the row sequencer. It accepts descriptors and drives fetch
//            requests and strobes.
//   slave  - the surrounding pipeline. This is the row-pointer reader plus the
//            fetch/MAC unit.
//
// Signals:
//   desc_valid/desc_ready/desc_base/desc_nnz/desc_last : row descriptor in
//   elem_valid/elem_ready/elem_addr/elem_last          : element fetch out
//   acc_clear, row_done, row_empty, mat_done           : one-cycle strobes
//   busy, rows_done                                    : status
// -----------------------------------------------------------------------------
interface smvm_row_sequencer_if #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16
);
    logic              desc_valid;
    logic              desc_ready;
    logic [ADDR_W-1:0] desc_base;
    logic [LEN_W-1:0]  desc_nnz;
    logic              desc_last;

    logic              elem_valid;
    logic              elem_ready;
    logic [ADDR_W-1:0] elem_addr;
    logic              elem_last;

    logic              acc_clear;
    logic              row_done;
    logic              row_empty;
    logic              mat_done;
    logic              busy;
    logic [31:0]       rows_done;

    modport master (
        input  desc_valid, desc_base, desc_nnz, desc_last, elem_ready,
        output desc_ready, elem_valid, elem_addr, elem_last,
               acc_clear, row_done, row_empty, mat_done, busy, rows_done
    );

    modport slave (
        output desc_valid, desc_base, desc_nnz, desc_last, elem_ready,
        input  desc_ready, elem_valid, elem_addr, elem_last,
               acc_clear, row_done, row_empty, mat_done, busy, rows_done
    );
endinterface

// File: rtl/smvm_row_sequencer.sv
// -----------------------------------------------------------------------------
// smvm_row_sequencer
// Walks one sparse-matrix row at a time. It takes a row descriptor (base
// address and nonzero count) and issues one element fetch request per nonzero,
// at contiguous addresses. The walk is bracketed by an accumulator-clear pulse
// at the start and a row-done pulse at the end. Outputs depend on registered
// state only.
//
// Ports:
//   clk  - clock; all state updates on posedge
//   rst  - synchronous active-high reset
//   bus  - smvm_row_sequencer_if.master (descriptor in, fetch out, strobes)
// -----------------------------------------------------------------------------
module smvm_row_sequencer #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    smvm_row_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e            state_q,     state_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [LEN_W-1:0]  cnt_q,       cnt_d;      // nonzeros still to issue
    logic              last_q,      last_d;     // row is the matrix's final row
    logic              empty_q,     empty_d;    // row had zero nonzeros
    logic              clear_q,     clear_d;    // acc_clear pulse register
    logic [31:0]       rows_done_q, rows_done_d;

    // NOTE: every variable gets its default before the case statement, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        empty_d     = empty_q;
        clear_d     = 1'b0;
        rows_done_d = rows_done_q;

        case (state_q)
            ST_IDLE: begin
                // desc_ready is high in IDLE, so desc_valid alone is the handshake.
                if (bus.desc_valid) begin
                    addr_d  = bus.desc_base;
                    cnt_d   = bus.desc_nnz;
                    last_d  = bus.desc_last;
                    clear_d = 1'b1;
                    if (bus.desc_nnz == '0) begin
                        empty_d = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        empty_d = 1'b0;
                        state_d = ST_ISSUE;
                    end
                end
            end

            ST_ISSUE: begin
                if (bus.elem_ready) begin
                    addr_d = addr_q + ADDR_W'(1);   // wraps modulo 2^ADDR_W
                    cnt_d  = cnt_q - LEN_W'(1);
                    // Leaving at a count of one means cnt never underflows.
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                rows_done_d = rows_done_q + 32'd1;
                state_d     = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments, and reset is sampled
    // only at the clock edge. A reset mid-row therefore abandons the row at
    // that edge, without a row_done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            last_q      <= 1'b0;
            empty_q     <= 1'b0;
            clear_q     <= 1'b0;
            rows_done_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            empty_q     <= empty_d;
            clear_q     <= clear_d;
            rows_done_q <= rows_done_d;
        end
    end

    assign bus.desc_ready = (state_q == ST_IDLE);
    assign bus.elem_valid = (state_q == ST_ISSUE);
    assign bus.elem_addr  = addr_q;
    assign bus.elem_last  = (state_q == ST_ISSUE) && (cnt_q == LEN_W'(1));
    assign bus.acc_clear  = clear_q;
    assign bus.row_done   = (state_q == ST_DONE);
    assign bus.row_empty  = (state_q == ST_DONE) && empty_q;
    assign bus.mat_done   = (state_q == ST_DONE) && last_q;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.rows_done  = rows_done_q;

endmodule

// File: tb/tb_smvm_row_sequencer.sv
// -----------------------------------------------------------------------------
// tb_smvm_row_sequencer
// Directed bench for smvm_row_sequencer. A transaction-level model keeps:
//   - a queue of the element addresses still owed for the current row, and
//   - an in-flight flag and a completed-row count.
// A single negedge process compares every DUT output against that model. The
// directed tests then pin the observed fetch stream and counters to
// hand-computed literals.
// -----------------------------------------------------------------------------
module tb_smvm_row_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    smvm_row_sequencer_if #(.ADDR_W(32), .LEN_W(16)) bus();

    smvm_row_sequencer #(.ADDR_W(32), .LEN_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- elem_ready driver ----------------
    bit       ready_mode = 1'b0;      // 0: always ready, 1: repeating 1,0,0,1
    logic [3:0] ready_pat = 4'b1001;  // bit i = ready value for step i
    initial begin
        int pidx = 0;
        bus.elem_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode) begin
                bus.elem_ready = ready_pat[pidx];
                pidx = (pidx + 1) % 4;
            end else begin
                bus.elem_ready = 1'b1;
                pidx = 0;
            end
        end
    end

    // ---------------- model + compare + observation ----------------
    logic [31:0] exp_q[$];          // addresses still owed for the current row
    bit          in_flight   = 1'b0;
    bit          clear_pend  = 1'b0;
    bit          cur_empty   = 1'b0;
    bit          cur_last    = 1'b0;
    bit          model_valid = 1'b0;
    logic [31:0] row_count   = '0;

    logic [31:0] obs_addr[$];
    bit          obs_last[$];
    int          obs_rows    = 0;
    int          obs_mat     = 0;
    int          mat_row     = 0;
    int          combo_cnt   = 0;
    int          cyc         = 0;
    int          accept_cyc  = 0;
    int          rowdone_cyc = 0;

    bit exp_valid, exp_done, was_idle;

    always @(negedge clk) begin
        cyc++;
        exp_valid = in_flight && (exp_q.size() > 0);
        exp_done  = in_flight && (exp_q.size() == 0);
        was_idle  = !in_flight;

        if (model_valid) begin
            check("desc_ready", bus.desc_ready, !in_flight);
            check("busy",       bus.busy,       in_flight);
            check("acc_clear",  bus.acc_clear,  clear_pend);
            check("elem_valid", bus.elem_valid, exp_valid);
            if (exp_valid) begin
                check("elem_addr", bus.elem_addr, exp_q[0]);
                check("elem_last", bus.elem_last, exp_q.size() == 1);
            end
            check("row_done",  bus.row_done,  exp_done);
            check("row_empty", bus.row_empty, exp_done && cur_empty);
            check("mat_done",  bus.mat_done,  exp_done && cur_last);
            check("rows_done", bus.rows_done, row_count);
        end

        // Observation log for the directed literal checks.
        if (!rst) begin
            if (bus.elem_valid === 1'b1 && bus.elem_ready === 1'b1) begin
                obs_addr.push_back(bus.elem_addr);
                obs_last.push_back(bus.elem_last);
            end
            if (bus.row_done === 1'b1) begin
                obs_rows++;
                rowdone_cyc = cyc;
                if (bus.mat_done === 1'b1) begin
                    obs_mat++;
                    mat_row = obs_rows;
                end
            end
            if (bus.acc_clear === 1'b1 && bus.row_done === 1'b1 &&
                bus.row_empty === 1'b1 && bus.mat_done === 1'b1) begin
                combo_cnt++;
            end
        end

        // Advance the model across the coming posedge.
        if (rst) begin
            exp_q.delete();
            in_flight   = 1'b0;
            clear_pend  = 1'b0;
            cur_empty   = 1'b0;
            cur_last    = 1'b0;
            row_count   = '0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            clear_pend = 1'b0;
            if (exp_done) begin
                in_flight = 1'b0;
                row_count = row_count + 32'd1;
            end else if (exp_valid && bus.elem_ready) begin
                void'(exp_q.pop_front());
            end
            if (was_idle && bus.desc_valid) begin
                for (int i = 0; i < int'(bus.desc_nnz); i++) begin
                    exp_q.push_back(bus.desc_base + 32'(i));
                end
                in_flight  = 1'b1;
                clear_pend = 1'b1;
                cur_empty  = (bus.desc_nnz == 16'd0);
                cur_last   = bus.desc_last;
                accept_cyc = cyc;
            end
        end
    end

    // ---------------- stimulus helpers (all start/end at posedge+1) ----------------
    task automatic clear_obs();
        obs_addr.delete();
        obs_last.delete();
        obs_rows  = 0;
        obs_mat   = 0;
        mat_row   = 0;
        combo_cnt = 0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.desc_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_desc_ready", bus.desc_ready, 1'b1);
        check("rst_busy",       bus.busy,       1'b0);
        check("rst_elem_valid", bus.elem_valid, 1'b0);
        check("rst_rows_done",  bus.rows_done,  32'd0);
        @(posedge clk);
        #1;
        clear_obs();
    endtask

    task automatic send_desc(input logic [31:0] base, input logic [15:0] nnz, input logic last);
        int k = 0;
        bus.desc_valid = 1'b1;
        bus.desc_base  = base;
        bus.desc_nnz   = nnz;
        bus.desc_last  = last;
        forever begin
            @(negedge clk);
            if (bus.desc_ready === 1'b1) break;
            k++;
            if (k > 200) begin
                check("desc_accept_timeout", 1'b0, 1'b1);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.desc_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        forever begin
            @(negedge clk);
            if (bus.busy === 1'b0) break;
            k++;
            if (k > 500) begin
                check("idle_timeout", 1'b0, 1'b1);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed tests ----------------
    initial begin
        bus.desc_valid = 1'b0;
        bus.desc_base  = '0;
        bus.desc_nnz   = '0;
        bus.desc_last  = 1'b0;

        // 1: basic 3-element row, always ready.
        do_reset();
        send_desc(32'h0000_0100, 16'd3, 1'b0);
        wait_idle();
        check("t1_count", obs_addr.size(), 3);
        if (obs_addr.size() == 3) begin
            check("t1_addr0", obs_addr[0], 32'h100);
            check("t1_addr1", obs_addr[1], 32'h101);
            check("t1_addr2", obs_addr[2], 32'h102);
            check("t1_last",  {obs_last[0], obs_last[1], obs_last[2]}, 3'b001);
        end
        check("t1_rows",      obs_rows, 1);
        check("t1_latency",   rowdone_cyc - accept_cyc, 4);
        check("t1_rows_done", bus.rows_done, 32'd1);

        // 2: empty final row.
        do_reset();
        send_desc(32'h0000_0200, 16'd0, 1'b1);
        wait_idle();
        check("t2_no_elems",  obs_addr.size(), 0);
        check("t2_combo",     combo_cnt, 1);
        check("t2_latency",   rowdone_cyc - accept_cyc, 1);
        check("t2_rows_done", bus.rows_done, 32'd1);

        // 3: 4-element row under back-pressure.
        do_reset();
        ready_mode = 1'b1;
        send_desc(32'h0000_0300, 16'd4, 1'b0);
        wait_idle();
        ready_mode = 1'b0;
        check("t3_count", obs_addr.size(), 4);
        if (obs_addr.size() == 4) begin
            check("t3_addr0", obs_addr[0], 32'h300);
            check("t3_addr3", obs_addr[3], 32'h303);
            check("t3_last",  {obs_last[0], obs_last[1], obs_last[2], obs_last[3]}, 4'b0001);
        end
        check("t3_rows_done", bus.rows_done, 32'd1);

        // 4: address wrap.
        do_reset();
        send_desc(32'hFFFF_FFFE, 16'd3, 1'b0);
        wait_idle();
        check("t4_count", obs_addr.size(), 3);
        if (obs_addr.size() == 3) begin
            check("t4_addr0", obs_addr[0], 32'hFFFF_FFFE);
            check("t4_addr1", obs_addr[1], 32'hFFFF_FFFF);
            check("t4_addr2", obs_addr[2], 32'h0000_0000);
        end

        // 5: reset while the 2nd of 5 elements is presented.
        do_reset();
        send_desc(32'h0000_0500, 16'd5, 1'b0);
        begin
            int k = 0;
            forever begin
                @(posedge clk);
                #1;
                if (bus.elem_valid === 1'b1 && bus.elem_addr === 32'h501) break;
                k++;
                if (k > 50) begin
                    check("t5_find_timeout", 1'b0, 1'b1);
                    break;
                end
            end
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("t5_valid_drop", bus.elem_valid, 1'b0);
        check("t5_no_done",    bus.row_done,   1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("t5_rows",      obs_rows, 0);
        check("t5_one_hs",    obs_addr.size(), 1);
        check("t5_rows_done", bus.rows_done, 32'd0);
        clear_obs();
        send_desc(32'h0000_0600, 16'd2, 1'b0);
        wait_idle();
        check("t5_new_count", obs_addr.size(), 2);
        if (obs_addr.size() == 2) begin
            check("t5_new_addr0", obs_addr[0], 32'h600);
            check("t5_new_addr1", obs_addr[1], 32'h601);
        end
        check("t5_new_rows_done", bus.rows_done, 32'd1);

        // 6: three back-to-back descriptors, last on the 3rd.
        do_reset();
        send_desc(32'h0000_0700, 16'd1, 1'b0);
        send_desc(32'h0000_0710, 16'd2, 1'b0);
        send_desc(32'h0000_0720, 16'd1, 1'b1);
        wait_idle();
        check("t6_count", obs_addr.size(), 4);
        if (obs_addr.size() == 4) begin
            check("t6_addr0", obs_addr[0], 32'h700);
            check("t6_addr1", obs_addr[1], 32'h710);
            check("t6_addr2", obs_addr[2], 32'h711);
            check("t6_addr3", obs_addr[3], 32'h720);
        end
        check("t6_rows",      obs_rows, 3);
        check("t6_mat_cnt",   obs_mat, 1);
        check("t6_mat_row",   mat_row, 3);
        check("t6_rows_done", bus.rows_done, 32'd3);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, expected completion");
        $fatal(1, "timeout");
    end

endmodule
